latch_fifo: RTL and testbench

Parametrised successor to the single-entry data latch: a DEPTH-entry, DATA_WIDTH-wide buffer between a producer that pulses `latch` and a consumer that drains with a valid/ack handshake. Unlike the single-entry latch, it accepts new data while older data is still waiting, exposes ready and occupancy, and counts rejected writes instead of silently ignoring them. It sits in the HWPE testbench datapath between stimulus sources and the accelerator stream ports.

---
 rtl/latch_fifo.sv | 88 ++++++++
 tb/tb_latch_fifo.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/latch_fifo.sv
// latch_fifo: DEPTH-entry circular buffer between a producer that pulses
// `latch` and a consumer that drains the head entry with out_vld/out_ack.
// Writes that arrive while the buffer is full are rejected and counted in a
// saturating drop counter.
//
// Ports
//   ap_clk     clock, all logic on the rising edge
//   ap_rst_n   synchronous active-low reset
//   latch      write request, captured when in_rdy=1
//   data_in    write data
//   in_rdy     buffer not full
//   flush      synchronous clear of buffer contents (drop_cnt kept)
//   out_vld    head entry valid
//   out_ack    consumer accepts head entry
//   data_out   head entry, 0 while empty
//   occupancy  number of stored entries
//   drop_cnt   rejected writes, saturating
//   drop_clr   clears drop_cnt
module latch_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     latch,
  input  logic [DATA_WIDTH-1:0]    data_in,
  output logic                     in_rdy,
  input  logic                     flush,
  output logic                     out_vld,
  input  logic                     out_ack,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_WIDTH-1:0]     drop_cnt,
  input  logic                     drop_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW-1:0]                    rd_ptr, wr_ptr;
  logic [AW:0]                      count;
  logic                             push, pop, drop;

  // Every output decodes from registered state only.
  assign in_rdy    = (count != FULL_CNT);
  assign out_vld   = (count != '0);
  assign occupancy = count;
  assign data_out  = out_vld ? mem[rd_ptr] : '0;

  // No ready-from-ack bypass when full and no fall-through when empty:
  // both handshakes look only at the registered count.
  assign push = latch & in_rdy & ~flush;
  assign pop  = out_vld & out_ack & ~flush;
  // A write discarded by flush is not a drop.
  assign drop = latch & ~in_rdy & ~flush;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; data_out is gated while empty.
  always_ff @(posedge ap_clk) begin
    if (ap_rst_n && push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n)                    drop_cnt <= '0;
    else if (drop_clr)                drop_cnt <= '0;
    else if (drop && drop_cnt != '1)  drop_cnt <= drop_cnt + 1'b1;
  end
endmodule

// File: tb/tb_latch_fifo.sv
module tb_latch_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 4;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n, latch, flush, out_ack, drop_clr;
  logic [DW-1:0] data_in;
  logic          in_rdy, out_vld;
  logic [DW-1:0] data_out;
  logic [2:0]    occupancy;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;
  int m_cnt  = 0;
  int m_drop = 0;
  logic [DW-1:0] exp_q[$];

  latch_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .latch(latch), .data_in(data_in),
    .in_rdy(in_rdy), .flush(flush), .out_vld(out_vld), .out_ack(out_ack),
    .data_out(data_out), .occupancy(occupancy), .drop_cnt(drop_cnt),
    .drop_clr(drop_clr)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: inputs are stable at the falling edge, so a handshake seen here
  // is the pop that the next rising edge performs.
  always @(negedge ap_clk) begin
    if (ap_rst_n && !flush && out_vld && out_ack) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", data_out);
      end else begin
        chk("data_order", data_out, exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; the model tracks acceptance, drops and flushes.
  task automatic cyc(input logic l, input logic [DW-1:0] d, input logic a,
                     input logic f = 1'b0, input logic dc = 1'b0);
    bit push_ok, pop_ok;
    latch = l; data_in = d; out_ack = a; flush = f; drop_clr = dc;
    push_ok = l && (m_cnt != DEPTH) && !f;
    pop_ok  = a && (m_cnt != 0) && !f;
    if (dc) m_drop = 0;
    else if (l && m_cnt == DEPTH && !f && m_drop != 15) m_drop++;
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (push_ok) exp_q.push_back(d);
      m_cnt = m_cnt + int'(push_ok) - int'(pop_ok);
    end
    @(posedge ap_clk); #1;
    latch = 0; out_ack = 0; flush = 0; drop_clr = 0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1);
  endtask

  initial begin
    ap_rst_n = 0; latch = 0; data_in = '0; flush = 0; out_ack = 0; drop_clr = 0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_drop", drop_cnt, 0);

    // single write
    cyc(1, 32'hA5A5_0001, 0);
    chk("single_vld", out_vld, 1);
    chk("single_data", data_out, 32'hA5A5_0001);
    chk("single_occ", occupancy, 1);
    cyc(0, 0, 1);
    chk("single_empty_vld", out_vld, 0);
    chk("single_empty_data", data_out, 0);

    // fill and overflow
    for (int i = 0; i < 4; i++) cyc(1, 32'h10 + i, 0);
    chk("full_in_rdy", in_rdy, 0);
    chk("full_occ", occupancy, 4);
    for (int i = 0; i < 3; i++) cyc(1, 32'hDEAD, 0);
    chk("ovf_drop", drop_cnt, 3);
    chk("ovf_occ", occupancy, 4);
    chk("ovf_head", data_out, 32'h10);
    drain(4);
    chk("drain_occ", occupancy, 0);

    // simultaneous push/pop at occupancy 2
    cyc(1, 32'h20, 0);
    cyc(1, 32'h21, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 32'h22 + i, 1);
      chk("pp_occ", occupancy, 2);
    end
    drain(2);

    // push+pop while full: pop only, one drop
    for (int i = 0; i < 4; i++) cyc(1, 32'h30 + i, 0);
    cyc(1, 32'h99, 1);
    chk("fullpp_occ", occupancy, 3);
    chk("fullpp_drop", drop_cnt, 4);
    chk("fullpp_in_rdy", in_rdy, 1);
    drain(3);

    // pointer wrap: 20 values streamed
    cyc(1, 32'h100, 0);
    for (int i = 1; i < 20; i++) cyc(1, 32'h100 + i, 1);
    cyc(0, 0, 1);
    chk("wrap_occ", occupancy, 0);

    // flush with latch at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1, 32'h50 + i, 0);
    chk("pre_flush_occ", occupancy, 3);
    cyc(1, 32'h55, 0, 1);
    chk("flush_occ", occupancy, 0);
    chk("flush_vld", out_vld, 0);
    chk("flush_drop", drop_cnt, 4);

    // reset mid-stream
    cyc(1, 32'h60, 0);
    cyc(1, 32'h61, 0);
    ap_rst_n = 0; exp_q.delete(); m_cnt = 0; m_drop = 0;
    @(posedge ap_clk); #1 ap_rst_n = 1;
    chk("mrst_occ", occupancy, 0);
    chk("mrst_vld", out_vld, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_in_rdy", in_rdy, 1);
    chk("mrst_drop", drop_cnt, 0);
    cyc(1, 32'h77, 0);
    chk("post_rst_occ", occupancy, 1);
    chk("post_rst_data", data_out, 32'h77);
    drain(1);

    // drop counter saturation and clear priority
    for (int i = 0; i < 4; i++) cyc(1, 32'h80 + i, 0);
    for (int i = 0; i < 20; i++) cyc(1, 32'hBAD, 0);
    chk("sat_drop", drop_cnt, 15);
    cyc(1, 32'hBAD, 0, 0, 1);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_occ", occupancy, 4);
    chk("clr_head", data_out, 32'h80);
    drain(4);

    chk("model_drop", drop_cnt, m_drop[CW-1:0]);
    chk("queue_empty", exp_q.size(), 0);
    chk("pop_total", n_pop, 44);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
